vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ==========================================================================
// vga_sync_decoder - recovers pixel coordinates and lock status from VGA syncs
// Revision 1.0
// ==========================================================================
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] rgb_in,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        lock_err,
  output logic [10:0] line_len
);

  localparam int          GW      = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOAL  = GW'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX   = 11'd2047;
  localparam logic [9:0]  V_MAX   = 10'd1023;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic          hs1_q, hs2_q, vs1_q, vs2_q;
  logic [11:0]   rgb1_q, rgb2_q;
  logic [10:0]   h_cnt_q, h_cnt_d, len_q, len_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          h_seen_q, v_seen_q, bad_q, bad_d;
  logic          h_fall, v_fall, h_bad, v_sat, frame_good;
  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic          lost_q, lost_d;

  logic          act_d, fs_d;
  logic [9:0]    x_d, y_d;
  logic [11:0]   rgb_d;
  logic          valid_q, fs_q, locked_q, err_q;
  logic [9:0]    x_q, y_q;
  logic [11:0]   rgb_q;
  logic [10:0]   line_len_q;

  assign h_fall = hs2_q & ~hs1_q;
  assign v_fall = vs2_q & ~vs1_q;

  always_comb begin
    h_cnt_d = h_fall ? 11'd0 : ((h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 11'd1);
    len_d   = len_q;
    // The first edge after reset has no preceding line to measure.
    if (h_fall && h_seen_q) begin
      len_d = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 11'd1;
    end
    h_bad = (h_fall && h_seen_q && (h_cnt_q != H_LAST)) || (!h_fall && (h_cnt_d == H_MAX));
    if (v_fall) begin
      v_cnt_d = 10'd0;
    end else if (h_fall && (v_cnt_q != V_MAX)) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end
    v_sat      = (v_cnt_d == V_MAX);
    frame_good = v_seen_q && (v_cnt_q == V_LAST) && !bad_q && !h_bad;
    bad_d      = v_fall ? 1'b0 : (bad_q | h_bad);
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    lost_d   = 1'b0;
    good_inc = good_q + GW'(1);
    case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        if (v_fall) begin
          if (frame_good) begin
            good_d = good_inc;
            if (good_inc == GOAL) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end else if (h_bad) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (h_bad || v_sat || (v_fall && !frame_good)) begin
          state_d = SEARCH;
          lost_d  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lost_q  <= lost_d;
    end
  end

  // Output stage reads the counters, which already reflect the S2 sample.
  always_comb begin
    act_d = (state_q == LOCKED) &&
            (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
            (v_cnt_q >= V_START) && (v_cnt_q < V_END);
    x_d   = act_d ? 10'(h_cnt_q - H_START) : 10'd0;
    y_d   = act_d ? (v_cnt_q - V_START) : 10'd0;
    rgb_d = act_d ? rgb2_q : 12'd0;
    fs_d  = act_d && (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      hs1_q      <= 1'b1;
      hs2_q      <= 1'b1;
      vs1_q      <= 1'b1;
      vs2_q      <= 1'b1;
      rgb1_q     <= '0;
      rgb2_q     <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      len_q      <= '0;
      h_seen_q   <= 1'b0;
      v_seen_q   <= 1'b0;
      bad_q      <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      line_len_q <= '0;
    end else begin
      hs1_q      <= hsync_in;
      hs2_q      <= hs1_q;
      vs1_q      <= vsync_in;
      vs2_q      <= vs1_q;
      rgb1_q     <= rgb_in;
      rgb2_q     <= rgb1_q;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      len_q      <= len_d;
      h_seen_q   <= h_seen_q | h_fall;
      v_seen_q   <= v_seen_q | v_fall;
      bad_q      <= bad_d;
      valid_q    <= act_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rgb_q      <= rgb_d;
      fs_q       <= fs_d;
      locked_q   <= (state_q == LOCKED);
      err_q      <= lost_q;
      line_len_q <= len_q;
    end
  end

  assign pixel_valid = valid_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_rgb   = rgb_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign lock_err    = err_q;
  assign line_len    = line_len_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// tb_vga_sync_decoder - frame-record table and hand sequences on a reduced raster,
// every cycle compared with a behavioural timing model.
module tb_vga_sync_decoder;

  localparam int HT = 40, HS = 4, HBP = 6, HA = 24;
  localparam int VT = 20, VS = 2, VBP = 3, VA = 12;
  localparam int LF = 2;
  localparam int S_SEARCH = 0, S_VERIFY = 1, S_LOCKED = 2;

  logic        clk_25MHz = 1'b0;
  logic        rst, hsync_in, vsync_in;
  logic [11:0] rgb_in;
  logic        pixel_valid, frame_start, locked, lock_err;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [10:0] line_len;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_start(frame_start), .locked(locked),
    .lock_err(lock_err), .line_len(line_len)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: positions are elapsed samples since the last sync edge.
  typedef struct {
    bit valid; int x; int y; int rgb; bit fs; bit lck; bit err; int len;
  } exp_t;

  exp_t pipe[$];
  int   m_t, m_thf, m_lines, m_st, m_good, m_len;
  bit   m_prev_h, m_prev_v, m_hseen, m_vseen, m_bad;

  function automatic int sat(input int a, input int m);
    return (a > m) ? m : a;
  endfunction

  task automatic model_step(input bit h, input bit v, input int rgb);
    bit hf, vf, hbad, vsat, good_frame, lost;
    int hc, vc;
    exp_t e;
    hf = m_prev_h && !h;
    vf = m_prev_v && !v;
    hbad = 0;
    if (hf) begin
      if (m_hseen) begin
        if (sat(m_t - 1 - m_thf, 2047) != HT - 1) hbad = 1;
        m_len = sat(m_t - m_thf, 2047);
      end
      m_hseen = 1;
      m_thf = m_t;
    end else if (m_t - m_thf >= 2047) begin
      hbad = 1;
    end
    good_frame = vf && m_vseen && (sat(m_lines, 1023) == VT - 1) && !m_bad && !hbad;
    if (vf) m_lines = 0;
    else if (hf) m_lines++;
    vsat = !vf && (m_lines >= 1023);
    m_bad = vf ? 1'b0 : (m_bad || hbad);
    if (vf) m_vseen = 1;
    lost = 0;
    if (m_st == S_SEARCH) begin
      if (vf) begin m_st = S_VERIFY; m_good = 0; end
    end else if (m_st == S_VERIFY) begin
      if (vf) begin
        if (good_frame) begin
          m_good++;
          if (m_good == LF) m_st = S_LOCKED;
        end else m_good = 0;
      end else if (hbad) m_good = 0;
    end else if (hbad || vsat || (vf && !good_frame)) begin
      m_st = S_SEARCH;
      lost = 1;
    end
    hc = sat(m_t - m_thf, 2047);
    vc = sat(m_lines, 1023);
    e.valid = (m_st == S_LOCKED) && hc >= HS + HBP && hc < HS + HBP + HA &&
              vc >= VS + VBP && vc < VS + VBP + VA;
    e.x   = e.valid ? hc - (HS + HBP) : 0;
    e.y   = e.valid ? vc - (VS + VBP) : 0;
    e.rgb = e.valid ? rgb : 0;
    e.fs  = e.valid && e.x == 0 && e.y == 0;
    e.lck = (m_st == S_LOCKED);
    e.err = lost;
    e.len = m_len;
    pipe.push_back(e);
    m_prev_h = h;
    m_prev_v = v;
    m_t++;
  endtask

  task automatic model_reset();
    exp_t z;
    z = '{default: 0};
    m_t = 0; m_thf = -1; m_lines = 0; m_st = S_SEARCH; m_good = 0; m_len = 0;
    m_prev_h = 1; m_prev_v = 1; m_hseen = 0; m_vseen = 0; m_bad = 0;
    pipe.delete();
    pipe.push_back(z);
    // The reset value of the sync registers acts as one idle sample.
    model_step(1'b1, 1'b1, 0);
  endtask

  int w_valid, w_fs, w_err, w_lenmin, w_lenmax, w_pat, mism;
  bit pat_mode;

  task automatic win_clear();
    w_valid = 0; w_fs = 0; w_err = 0; w_lenmin = 4096; w_lenmax = 0; w_pat = 0; mism = 0;
  endtask

  task automatic step(input bit h, input bit v, input logic [11:0] rgb);
    exp_t e;
    hsync_in = h;
    vsync_in = v;
    rgb_in   = rgb;
    @(posedge clk_25MHz);
    model_step(h, v, int'(rgb));
    #1;
    e = pipe.pop_front();
    if (pixel_valid !== e.valid || pixel_x !== 10'(e.x) || pixel_y !== 10'(e.y) ||
        pixel_rgb !== 12'(e.rgb) || frame_start !== e.fs || locked !== e.lck ||
        lock_err !== e.err || line_len !== 11'(e.len))
      mism++;
    if (pixel_valid) w_valid++;
    if (frame_start) w_fs++;
    if (lock_err) w_err++;
    if (line_len != 0 && int'(line_len) < w_lenmin) w_lenmin = int'(line_len);
    if (int'(line_len) > w_lenmax) w_lenmax = int'(line_len);
    if (pat_mode && pixel_valid && pixel_rgb != {pixel_x[3:0], pixel_y[3:0], 4'hA}) w_pat++;
  endtask

  task automatic send_frame(input int lines, input int short_idx, input int short_len,
                            input bit pattern);
    pat_mode = pattern;
    for (int l = 0; l < lines; l++) begin
      int len;
      len = (l == short_idx) ? short_len : HT;
      for (int p = 0; p < len; p++) begin
        int x, y;
        logic [11:0] c;
        x = p - (HS + HBP);
        y = l - (VS + VBP);
        c = pattern ? {x[3:0], y[3:0], 4'hA} : 12'($urandom);
        step(p >= HS, l >= VS, c);
      end
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    rst = 1'b1;
    repeat (n) @(posedge clk_25MHz);
    #1;
    check({tag, "_valid"}, int'(pixel_valid), 0);
    check({tag, "_x"}, int'(pixel_x), 0);
    check({tag, "_y"}, int'(pixel_y), 0);
    check({tag, "_rgb"}, int'(pixel_rgb), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_err"}, int'(lock_err), 0);
    check({tag, "_len"}, int'(line_len), 0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int lines; int short_idx; int short_len; bit pattern;
    int exp_valid; int exp_fs; int exp_err; bit exp_locked; int exp_lenmin;
  } frame_rec_t;

  frame_rec_t tbl[14];

  initial begin
    tbl[0]  = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[1]  = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[2]  = '{20, -1,  0, 1'b1, 288, 1, 0, 1'b1, 40};
    tbl[3]  = '{20, -1,  0, 1'b0, 288, 1, 0, 1'b1, 40};
    tbl[4]  = '{20,  8, 39, 1'b0,  96, 1, 1, 1'b0, 39};
    tbl[5]  = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[6]  = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[7]  = '{20, -1,  0, 1'b1, 288, 1, 0, 1'b1, 40};
    tbl[8]  = '{19, -1,  0, 1'b0, 288, 1, 0, 1'b1, 40};
    tbl[9]  = '{20, -1,  0, 1'b0,   0, 0, 1, 1'b0, 40};
    tbl[10] = '{19, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[11] = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[12] = '{20, -1,  0, 1'b0,   0, 0, 0, 1'b0, 40};
    tbl[13] = '{20, -1,  0, 1'b1, 288, 1, 0, 1'b1, 40};

    rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0; pat_mode = 1'b0;
    do_reset(3, "reset");

    for (int i = 0; i < 14; i++) begin
      win_clear();
      send_frame(tbl[i].lines, tbl[i].short_idx, tbl[i].short_len, tbl[i].pattern);
      check($sformatf("rec%0d_valid", i), w_valid, tbl[i].exp_valid);
      check($sformatf("rec%0d_fs", i), w_fs, tbl[i].exp_fs);
      check($sformatf("rec%0d_err", i), w_err, tbl[i].exp_err);
      check($sformatf("rec%0d_locked", i), int'(locked), int'(tbl[i].exp_locked));
      check($sformatf("rec%0d_lenmin", i), w_lenmin, tbl[i].exp_lenmin);
      check($sformatf("rec%0d_model", i), mism, 0);
      if (tbl[i].pattern) check($sformatf("rec%0d_pattern", i), w_pat, 0);
    end

    // hsync stuck high while locked: h_cnt saturates and lock drops once
    win_clear();
    pat_mode = 1'b0;
    repeat (3000) step(1'b1, 1'b1, 12'($urandom));
    check("hold_err", w_err, 1);
    check("hold_locked", int'(locked), 0);
    check("hold_valid", w_valid, 0);
    check("hold_model", mism, 0);
    win_clear();
    send_frame(20, -1, 0, 1'b0);
    check("hold_len_sat", w_lenmax, 2047);
    send_frame(20, -1, 0, 1'b0);
    check("hold_f2_locked", int'(locked), 0);
    send_frame(20, -1, 0, 1'b1);
    check("hold_relock", int'(locked), 1);
    check("hold_relock_valid", w_valid, 288);
    check("hold_relock_model", mism, 0);

    // reset pulse in the middle of an active line while locked
    win_clear();
    send_frame(8, -1, 0, 1'b0);
    for (int p = 0; p < 20; p++) step(p >= HS, 1'b1, 12'($urandom));
    check("pre_rst_locked", int'(locked), 1);
    do_reset(1, "rst_mid");
    win_clear();
    send_frame(20, -1, 0, 1'b0);
    send_frame(20, -1, 0, 1'b0);
    check("rst_f2_locked", int'(locked), 0);
    send_frame(20, -1, 0, 1'b1);
    check("rst_err", w_err, 0);
    check("rst_relock", int'(locked), 1);
    check("rst_valid", w_valid, 288);
    check("rst_fs", w_fs, 1);
    check("rst_pattern", w_pat, 0);
    check("rst_model", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
